// File: rtl/shift_seq_ctrl_pkg.sv
// shift_seq_ctrl_pkg: op/state encodings and effective shift amount for shift_seq_ctrl
package shift_seq_ctrl_pkg;
   typedef enum logic [2:0] {OP_LSL = 3'd0, OP_LSR = 3'd1, OP_ASR = 3'd2, OP_ROL = 3'd3, OP_ROR = 3'd4} op_t;
   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
   function automatic op_t norm_op(input logic [2:0] op);
      return op > 3'd4 ? OP_LSL : op_t'(op);
   endfunction
   // rotates wrap modulo the width, plain shifts saturate at the width
   function automatic int eff_amt(input op_t op, input int amt, input int w);
      return (op == OP_ROL || op == OP_ROR) ? amt % w : (amt > w ? w : amt);
   endfunction
endpackage

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: runs multi-bit shift/rotate commands on a loadable single-bit shift register
module shift_seq_ctrl
   import shift_seq_ctrl_pkg::*;
#(
   parameter int W  = 8,
   parameter int CW = $clog2(W) + 1
) (
   input  logic          clk,
   input  logic          rst_b,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [2:0]    cmd_op,
   input  logic [W-1:0]  cmd_data,
   input  logic [CW-1:0] cmd_amt,
   input  logic          abort,
   output logic          r_ld,
   output logic          r_clr,
   output logic          r_ls,
   output logic          r_rs,
   output logic          r_left,
   output logic          r_right,
   output logic [W-1:0]  r_d,
   input  logic [W-1:0]  r_q,
   output logic          res_valid,
   input  logic          res_ready,
   output logic [W-1:0]  res_data,
   output logic          res_carry
);
   state_t        state;
   op_t           op;
   logic [W-1:0]  data;
   logic [CW-1:0] cnt;
   logic          carry;
   logic          clr;
   logic          lft;
   logic          shf;
   assign lft       = op == OP_LSL || op == OP_ROL;
   assign shf       = state == SHIFT;
   // the clear cycle after an abort holds off new commands
   assign cmd_ready = state == IDLE && !clr;
   assign r_clr     = clr;
   assign r_ld      = state == LOAD;
   assign r_d       = state == LOAD ? data : '0;
   assign r_ls      = shf && lft;
   assign r_rs      = shf && !lft;
   assign r_right   = shf && op == OP_ROL && r_q[W-1];
   assign r_left    = shf && ((op == OP_ASR && r_q[W-1]) || (op == OP_ROR && r_q[0]));
   assign res_valid = state == DONE;
   assign res_data  = res_valid ? r_q : '0;
   assign res_carry = res_valid && carry;
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state <= IDLE;
         op    <= OP_LSL;
         data  <= '0;
         cnt   <= '0;
         carry <= 1'b0;
         clr   <= 1'b0;
      end else begin
         clr <= abort && state != IDLE;
         if (abort && state != IDLE) state <= IDLE;
         else
            case (state)
               IDLE:
                  if (cmd_valid && cmd_ready) begin
                     op    <= norm_op(cmd_op);
                     data  <= cmd_data;
                     cnt   <= CW'(eff_amt(norm_op(cmd_op), int'(cmd_amt), W));
                     state <= LOAD;
                  end
               LOAD: begin
                  carry <= 1'b0;
                  state <= cnt != '0 ? SHIFT : DONE;
               end
               SHIFT: begin
                  carry <= lft ? r_q[W-1] : r_q[0];
                  cnt   <= cnt - 1'b1;
                  if (cnt == CW'(1)) state <= DONE;
               end
               DONE: if (res_ready) state <= IDLE;
               default: state <= IDLE;
            endcase
      end
   end
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: drives shift_seq_ctrl paired with a behavioural shift register
module tb_shift_seq_ctrl;
   localparam int W = 8;
   localparam int CW = 4;
   logic          clk = 1'b0;
   logic          rst_b = 1'b0;
   logic          cmd_valid = 1'b0, cmd_ready;
   logic [2:0]    cmd_op = '0;
   logic [W-1:0]  cmd_data = '0;
   logic [CW-1:0] cmd_amt = '0;
   logic          abort = 1'b0;
   logic          r_ld, r_clr, r_ls, r_rs, r_left, r_right;
   logic [W-1:0]  r_d, q;
   logic          res_valid, res_ready = 1'b1, res_carry;
   logic [W-1:0]  res_data;
   int            nvec = 0, nerr = 0, oh_err = 0;
   int            rs_cnt = 0, clr_cnt = 0, rv_cnt = 0;

   shift_seq_ctrl #(.W(W), .CW(CW)) dut (
      .clk(clk), .rst_b(rst_b), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_amt(cmd_amt), .abort(abort),
      .r_ld(r_ld), .r_clr(r_clr), .r_ls(r_ls), .r_rs(r_rs), .r_left(r_left),
      .r_right(r_right), .r_d(r_d), .r_q(q), .res_valid(res_valid),
      .res_ready(res_ready), .res_data(res_data), .res_carry(res_carry)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_b)
      if (!rst_b) q <= '0;
      else if (r_clr) q <= '0;
      else if (r_ld) q <= r_d;
      else if (r_ls) q <= {q[W-2:0], r_right};
      else if (r_rs) q <= {r_left, q[W-1:1]};

   always @(posedge clk) begin
      if (r_rs) rs_cnt <= rs_cnt + 1;
      if (r_clr) clr_cnt <= clr_cnt + 1;
      if (res_valid) rv_cnt <= rv_cnt + 1;
   end

   always @(negedge clk)
      if ($countones({r_ld, r_clr, r_ls, r_rs}) > 1) begin
         oh_err <= oh_err + 1;
         $display("FAIL onehot: controls %b at %0t", {r_ld, r_clr, r_ls, r_rs}, $time);
      end

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] data;
      logic [CW-1:0] amt;
      logic [W-1:0] exp_q;
      logic         exp_c;
      int           lat;
      int           rs;
   } vec_t;
   vec_t tv[11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [24:0] outs();
      return {cmd_ready, res_valid, r_ld, r_clr, r_ls, r_rs, r_left, r_right, r_d, res_data, res_carry};
   endfunction

   // call at a negedge; returns at the negedge right after the handshake edge
   task automatic send(input logic [2:0] op, input logic [W-1:0] data, input logic [CW-1:0] amt);
      int i = 0;
      cmd_op = op;
      cmd_data = data;
      cmd_amt = amt;
      cmd_valid = 1'b1;
      while (!cmd_ready && i < 50) begin
         @(negedge clk);
         i++;
      end
      if (!cmd_ready) begin
         $display("FAIL send: cmd_ready never rose");
         nerr++;
      end
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_res(output int lat);
      lat = 1;
      while (!res_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
   endtask

   initial begin
      int lat, rs0, clr0, rv0;
      tv[0]  = '{3'd0, 8'h81, 4'd1,  8'h02, 1'b1, 3,  0};
      tv[1]  = '{3'd2, 8'h90, 4'd3,  8'hF2, 1'b0, 5,  3};
      tv[2]  = '{3'd1, 8'h90, 4'd3,  8'h12, 1'b0, 5,  3};
      tv[3]  = '{3'd4, 8'h01, 4'd9,  8'h80, 1'b1, 3,  1};
      tv[4]  = '{3'd3, 8'hA5, 4'd8,  8'hA5, 1'b0, 2,  0};
      tv[5]  = '{3'd1, 8'hFF, 4'd15, 8'h00, 1'b1, 10, 8};
      tv[6]  = '{3'd3, 8'h81, 4'd3,  8'h0C, 1'b0, 5,  0};
      tv[7]  = '{3'd4, 8'h81, 4'd2,  8'h60, 1'b0, 4,  2};
      tv[8]  = '{3'd7, 8'h01, 4'd8,  8'h00, 1'b1, 10, 0};
      tv[9]  = '{3'd2, 8'h3F, 4'd2,  8'h0F, 1'b1, 4,  2};
      tv[10] = '{3'd0, 8'h55, 4'd0,  8'h55, 1'b0, 2,  0};
      @(negedge clk);
      chk("reset_outs", 32'(outs()), 32'({1'b1, 24'd0}));
      rst_b = 1'b1;
      @(negedge clk);
      chk("idle_outs", 32'(outs()), 32'({1'b1, 24'd0}));
      foreach (tv[k]) begin
         rs0 = rs_cnt;
         send(tv[k].op, tv[k].data, tv[k].amt);
         wait_res(lat);
         chk($sformatf("v%0d_lat", k), 32'(lat), 32'(tv[k].lat));
         chk($sformatf("v%0d_data", k), 32'(res_data), 32'(tv[k].exp_q));
         chk($sformatf("v%0d_carry", k), 32'(res_carry), 32'(tv[k].exp_c));
         chk($sformatf("v%0d_rs", k), 32'(rs_cnt - rs0), 32'(tv[k].rs));
         @(negedge clk);
      end
      // backpressure: result held, next command waits
      res_ready = 1'b0;
      send(3'd0, 8'h0F, 4'd2);
      wait_res(lat);
      chk("bp_lat", 32'(lat), 32'd4);
      cmd_op = 3'd1;
      cmd_data = 8'h80;
      cmd_amt = 4'd1;
      cmd_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", 32'(res_valid), 32'd1);
         chk("bp_data", 32'(res_data), 32'h3C);
         chk("bp_ready", 32'(cmd_ready), 32'd0);
         @(negedge clk);
      end
      res_ready = 1'b1;
      send(3'd1, 8'h80, 4'd1);
      wait_res(lat);
      chk("bp_next_lat", 32'(lat), 32'd3);
      chk("bp_next_data", 32'(res_data), 32'h40);
      @(negedge clk);
      // abort during the second shift
      clr0 = clr_cnt;
      send(3'd0, 8'hFF, 4'd6);
      @(negedge clk);
      @(negedge clk);
      chk("ab_shifting", 32'(r_ls), 32'd1);
      abort = 1'b1;
      rv0 = rv_cnt;
      @(negedge clk);
      abort = 1'b0;
      chk("ab_clr", 32'(r_clr), 32'd1);
      chk("ab_ready_lo", 32'(cmd_ready), 32'd0);
      @(negedge clk);
      chk("ab_clr_off", 32'(r_clr), 32'd0);
      chk("ab_idle", 32'(cmd_ready), 32'd1);
      chk("ab_q", 32'(q), 32'd0);
      repeat (10) @(negedge clk);
      chk("ab_clr_pulses", 32'(clr_cnt - clr0), 32'd1);
      chk("ab_no_res", 32'(rv_cnt - rv0), 32'd0);
      // asynchronous reset mid-shift
      send(3'd0, 8'hFF, 4'd6);
      @(negedge clk);
      @(negedge clk);
      rv0 = rv_cnt;
      #1 rst_b = 1'b0;
      #1 chk("rst_async", 32'(outs()), 32'({1'b1, 24'd0}));
      @(negedge clk);
      rst_b = 1'b1;
      repeat (10) @(negedge clk);
      chk("rst_no_res", 32'(rv_cnt - rv0), 32'd0);
      send(3'd2, 8'h90, 4'd3);
      wait_res(lat);
      chk("rst_recover", 32'({res_data, res_carry}), 32'({8'hF2, 1'b0}));
      @(negedge clk);
      chk("onehot_errs", 32'(oh_err), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
